// File: rtl/mul_accumulate_stage_if.sv
// Product-in / sum-out bundle between the shift multiplier, the accumulate stage and its consumer.
// master is the surrounding logic, slave is the accumulate stage.
interface mul_accumulate_stage_if #(
    parameter int unsigned W_IN  = 32,
    parameter int unsigned W_ACC = 40,
    parameter int unsigned CNT_W = 8
);
    logic [W_IN-1:0]  c;
    logic             result_vld;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic [W_ACC-1:0] sum;
    logic             sum_vld;
    logic             sum_rdy;
    logic             ovf;
    logic             drop;

    modport master (
        output c, result_vld, start, len, sum_rdy,
        input  busy, sum, sum_vld, ovf, drop
    );

    modport slave (
        input  c, result_vld, start, len, sum_rdy,
        output busy, sum, sum_vld, ovf, drop
    );
endinterface

// File: rtl/mul_accumulate_stage.sv
// Sums a programmed number of multiplier products into a saturating accumulator and
// offers the finished sum downstream over a valid/ready handshake.
module mul_accumulate_stage #(
    parameter int unsigned W_IN  = 32,
    parameter int unsigned W_ACC = 40,
    parameter int unsigned CNT_W = 8
) (
    input logic                   clk,
    input logic                   rst,
    mul_accumulate_stage_if.slave bus
);
    localparam int unsigned EXT_W = W_ACC + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [W_ACC-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic             ovf_q;
    logic             vld_q;
    logic             busy_q;
    logic             sum_vld_q;
    logic             drop_q;

    logic [W_IN-1:0]  prod;
    logic             capture;
    logic [EXT_W-1:0] acc_ext;
    logic             carry;
    logic [CNT_W-1:0] cnt_inc;

    // One capture per rising edge of result_vld, so a held level counts once.
    assign prod    = bus.c;
    assign capture = bus.result_vld & ~vld_q;
    assign acc_ext = {1'b0, acc} + EXT_W'(prod);
    assign carry   = acc_ext[W_ACC];
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            sum_vld_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            vld_q  <= bus.result_vld;
            drop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        ovf_q  <= 1'b0;
                        len_q  <= bus.len;
                        busy_q <= 1'b1;
                        // A zero-length job completes immediately with sum 0.
                        if (bus.len == '0) begin
                            state     <= HOLD;
                            sum_vld_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (capture) begin
                        acc   <= carry ? '1 : acc_ext[W_ACC-1:0];
                        ovf_q <= ovf_q | carry;
                        cnt   <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state     <= HOLD;
                            sum_vld_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (capture) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.sum_rdy) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        sum_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    sum_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.sum     = acc;
    assign bus.sum_vld = sum_vld_q;
    assign bus.ovf     = ovf_q;
    assign bus.drop    = drop_q;
endmodule
